// File: rtl/mem_wait_bridge_if.sv
// Memory-side request/acknowledge bus of mem_wait_bridge.
// The bridge drives the master modport and the memory drives the slave modport.
interface mem_wait_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_wait_bridge.sv
// Turns single-cycle MemRead/MemWrite strobes into a req/ack memory transaction.
// The core is stalled until ack, and errors are raised for misaligned accesses or a missing ack.
module mem_wait_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_err,
  mem_wait_bridge_if.master mem
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             core_req;
  logic             aligned;

  assign core_req = core_re | core_we;
  assign aligned  = (core_adr[1:0] == 2'b00);

  // Combinational so the core freezes in the same cycle it issues the request.
  assign core_stall = !rst && (((state == IDLE) && core_req && aligned) || (state == REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      core_rdata    <= '0;
      core_err      <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_adr   <= '0;
      mem.mem_wdata <= '0;
    end else begin
      core_err <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req) begin
            if (aligned) begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= core_we;
              mem.mem_adr   <= core_adr;
              mem.mem_wdata <= core_wdata;
              cnt           <= '0;
              state         <= REQ;
            end else begin
              core_err <= 1'b1;
              state    <= ERR;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) begin
              core_rdata <= mem.mem_rdata;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              mem.mem_req <= 1'b0;
              core_err    <= 1'b1;
              state       <= ERR;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench for mem_wait_bridge: each cycle starts 1ns after the rising edge,
// inputs are applied, and outputs are compared 1ns later.
module tb_mem_wait_bridge;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_re;
  logic              core_we;
  logic [ADDR_W-1:0] core_adr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              core_err;

  int checks = 0;
  int fails  = 0;

  mem_wait_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  mem_wait_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_adr   (core_adr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_err   (core_err),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle, 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi_cnt;
    bit seen_err;

    rst = 1'b1; core_re = 1'b1; core_we = 1'b0; core_adr = '0; core_wdata = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    tick(); tick();
    settle();
    check("rst_stall", {31'b0, core_stall}, 32'd0);
    check("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_err", {31'b0, core_err}, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_adr", mem_bus.mem_adr, 32'd0);
    core_re = 1'b0;
    tick();
    rst = 1'b0;

    // Aligned read, ack on first REQ cycle
    tick();
    core_re = 1'b1; core_adr = 32'h8;
    settle();
    check("t1_stall_c0", {31'b0, core_stall}, 32'd1);
    check("t1_req_c0", {31'b0, mem_bus.mem_req}, 32'd0);
    tick();
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF;
    settle();
    check("t1_req_c1", {31'b0, mem_bus.mem_req}, 32'd1);
    check("t1_we_c1", {31'b0, mem_bus.mem_we}, 32'd0);
    check("t1_adr_c1", mem_bus.mem_adr, 32'h8);
    check("t1_stall_c1", {31'b0, core_stall}, 32'd1);
    tick();
    mem_bus.mem_ack = 1'b0; core_re = 1'b0;
    settle();
    check("t1_stall_c2", {31'b0, core_stall}, 32'd0);
    check("t1_req_c2", {31'b0, mem_bus.mem_req}, 32'd0);
    check("t1_rdata", core_rdata, 32'hDEADBEEF);
    check("t1_err", {31'b0, core_err}, 32'd0);
    tick();

    // Write, ack on fourth REQ cycle
    core_we = 1'b1; core_adr = 32'h10; core_wdata = 32'h1234;
    settle();
    check("t2_stall_c0", {31'b0, core_stall}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BAD0BAD;
      end
      settle();
      check($sformatf("t2_req_c%0d", c), {31'b0, mem_bus.mem_req}, 32'd1);
      check($sformatf("t2_we_c%0d", c), {31'b0, mem_bus.mem_we}, 32'd1);
      check($sformatf("t2_adr_c%0d", c), mem_bus.mem_adr, 32'h10);
      check($sformatf("t2_wdata_c%0d", c), mem_bus.mem_wdata, 32'h1234);
      check($sformatf("t2_stall_c%0d", c), {31'b0, core_stall}, 32'd1);
    end
    tick();
    mem_bus.mem_ack = 1'b0; core_we = 1'b0;
    settle();
    check("t2_stall_c5", {31'b0, core_stall}, 32'd0);
    check("t2_req_c5", {31'b0, mem_bus.mem_req}, 32'd0);
    check("t2_rdata_kept", core_rdata, 32'hDEADBEEF);
    tick();

    // Misaligned read
    core_re = 1'b1; core_adr = 32'h6;
    settle();
    check("t3_stall_c0", {31'b0, core_stall}, 32'd0);
    tick();
    settle();
    check("t3_req_c1", {31'b0, mem_bus.mem_req}, 32'd0);
    check("t3_err_c1", {31'b0, core_err}, 32'd1);
    check("t3_stall_c1", {31'b0, core_stall}, 32'd0);
    core_re = 1'b0;
    tick();
    settle();
    check("t3_err_c2", {31'b0, core_err}, 32'd0);
    check("t3_rdata_kept", core_rdata, 32'hDEADBEEF);

    // Read with no ack: timeout after exactly TIMEOUT REQ cycles
    core_re = 1'b1; core_adr = 32'h40;
    hi_cnt = 0; seen_err = 1'b0;
    for (int c = 0; c < 40 && !seen_err; c++) begin
      tick();
      settle();
      if (mem_bus.mem_req) hi_cnt++;
      else if (hi_cnt > 0) begin
        seen_err = 1'b1;
        check("t4_err_pulse", {31'b0, core_err}, 32'd1);
        check("t4_stall_err", {31'b0, core_stall}, 32'd0);
        core_re = 1'b0;
      end
    end
    check("t4_seen_err", {31'b0, seen_err}, 32'd1);
    check("t4_req_cycles", hi_cnt, TIMEOUT);
    tick();
    settle();
    check("t4_err_clear", {31'b0, core_err}, 32'd0);

    // Ack arriving on the final allowed REQ cycle completes normally
    core_re = 1'b1; core_adr = 32'h44;
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      if (c == TIMEOUT) begin
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
      end
      settle();
      check($sformatf("t4b_req_c%0d", c), {31'b0, mem_bus.mem_req}, 32'd1);
    end
    tick();
    mem_bus.mem_ack = 1'b0; core_re = 1'b0;
    settle();
    check("t4b_err", {31'b0, core_err}, 32'd0);
    check("t4b_req_done", {31'b0, mem_bus.mem_req}, 32'd0);
    check("t4b_rdata", core_rdata, 32'hCAFEF00D);
    tick();

    // Read and write together: write wins
    core_re = 1'b1; core_we = 1'b1; core_adr = 32'h20; core_wdata = 32'h55;
    tick();
    mem_bus.mem_ack = 1'b1;
    settle();
    check("t5_we", {31'b0, mem_bus.mem_we}, 32'd1);
    check("t5_adr", mem_bus.mem_adr, 32'h20);
    tick();
    mem_bus.mem_ack = 1'b0; core_re = 1'b0; core_we = 1'b0;
    settle();
    check("t5_rdata_kept", core_rdata, 32'hCAFEF00D);
    tick();

    // Spurious ack in IDLE is ignored
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h11111111;
    tick(); tick();
    settle();
    check("t5_spur_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("t5_spur_stall", {31'b0, core_stall}, 32'd0);
    check("t5_spur_err", {31'b0, core_err}, 32'd0);
    check("t5_spur_rdata", core_rdata, 32'hCAFEF00D);
    mem_bus.mem_ack = 1'b0;
    tick();

    // Reset asserted mid-REQ
    core_re = 1'b1; core_adr = 32'h80;
    tick();
    settle();
    check("t6_req_before", {31'b0, mem_bus.mem_req}, 32'd1);
    rst = 1'b1;
    settle();
    check("t6_req_rst", {31'b0, mem_bus.mem_req}, 32'd0);
    check("t6_stall_rst", {31'b0, core_stall}, 32'd0);
    check("t6_err_rst", {31'b0, core_err}, 32'd0);
    check("t6_rdata_rst", core_rdata, 32'd0);
    core_re = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    core_re = 1'b1; core_adr = 32'h84;
    settle();
    check("t6_stall_new", {31'b0, core_stall}, 32'd1);
    tick();
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BADCAFE;
    settle();
    check("t6_req_new", {31'b0, mem_bus.mem_req}, 32'd1);
    check("t6_adr_new", mem_bus.mem_adr, 32'h84);
    tick();
    mem_bus.mem_ack = 1'b0; core_re = 1'b0;
    settle();
    check("t6_rdata_new", core_rdata, 32'h0BADCAFE);
    check("t6_stall_done", {31'b0, core_stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
